// File: rtl/key_scan_enc_pkg.sv
// key_pkg: shared state encoding, key widths and priority encoder for key_scan_enc
package key_pkg;

    localparam int KEY_N  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    function automatic logic [CODE_W-1:0] prio_enc8(input logic [KEY_N-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_N; i++)
            if (v[i]) r = CODE_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/key_scan_enc_sync.sv
// key_sync: generic N-bit two-flop synchroniser with synchronous active-low reset
module key_sync #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] s1;

    // two back-to-back flops to resolve metastability on the raw inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/key_scan_enc.sv
// key_scan_enc: sync, whole-vector debounce and priority encode of 8 buttons; KEY_REPEAT_EN adds auto-repeat
module key_scan_enc
    import key_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000,
    parameter int CNT_W         = 20,
    parameter int REPEAT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_N-1:0]  keys_raw,
    output logic [CODE_W-1:0] keyin,
    output logic              key_valid,
    output logic              key_held
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2 || DEB_CYCLES > (1 << CNT_W) || REPEAT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
        $error("key_scan_enc: DEB_CYCLES/REPEAT_CYCLES must be >=2 and fit in CNT_W");
    end

    logic [KEY_N-1:0] ks, ks_d, last;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    state_t           state;

    key_sync #(.N(KEY_N)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (keys_raw),
        .q     (ks)
    );

    assign stable = (ks == ks_d) && (cnt == DEB_LAST);

    // stability counter: restarts on any change of the synchronised vector, saturates at DEB_CYCLES-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ks_d <= '0;
            cnt  <= '0;
        end else begin
            ks_d <= ks;
            cnt  <= (ks != ks_d) ? '0 : (cnt == DEB_LAST) ? cnt : cnt + 1'b1;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt;

    // held-cycle counter; zero outside HELD so every entry to HELD starts a fresh period
    always_ff @(posedge clk) begin
        if (!rst_n) rcnt <= '0;
        else rcnt <= (state != HELD || rcnt == RPT_LAST) ? '0 : rcnt + 1'b1;
    end
`endif

    // press/release FSM with registered outputs; last remembers the accepted vector to spot bounces
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            keyin     <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            last      <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: if (ks != '0) state <= PRESS_DB;
                PRESS_DB:
                    if (ks == '0) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                    end else if (stable) begin
                        state     <= HELD;
                        keyin     <= prio_enc8(ks);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        last      <= ks;
                    end
                HELD:
                    if (ks == '0) state <= REL_DB;
                    else if (ks != last) state <= PRESS_DB;
`ifdef KEY_REPEAT_EN
                    else if (rcnt == RPT_LAST) key_valid <= 1'b1;
`endif
                REL_DB:
                    if (ks == last) state <= HELD;
                    else if (ks != '0) state <= PRESS_DB;
                    else if (stable) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
